// File: rtl/serial_word_deframer.sv
// Serial-to-parallel word deframer: hunts for a sync word, locks onto it,
// emits framed data words and drops lock after repeated bad sync slots.
module serial_word_deframer #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC        = 8'hA5,
    parameter int               FRAME_WORDS = 4,
    parameter int               MISS_MAX    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    input  logic             e,
    output logic [WIDTH-1:0] q_data,
    output logic             q_valid,
    output logic             locked,
    output logic             sync_err
);

    localparam int BW = $clog2(WIDTH);
    localparam int WW = $clog2(FRAME_WORDS + 1);
    localparam int MW = $clog2(MISS_MAX + 1);
    localparam int FW = $clog2(WIDTH + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [WW-1:0] WORD_SYNC = WW'(FRAME_WORDS);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);
    localparam logic [FW-1:0] FILL_MAX  = FW'(WIDTH);
    localparam logic [FW-1:0] FILL_MIN  = FW'(WIDTH - 1);

    typedef enum logic {
        S_HUNT,
        S_LOCKED
    } state_t;

    state_t           r_state;
    // Only the WIDTH-1 most recent bits are needed to form the next word.
    logic [WIDTH-2:0] r_sr;
    logic [FW-1:0]    r_fill;
    logic [BW-1:0]    r_bitcnt;
    logic [WW-1:0]    r_wordcnt;
    logic [MW-1:0]    r_missed;
    logic [WIDTH-1:0] w_nxt;

    assign w_nxt = {r_sr, i};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_HUNT;
            r_sr      <= '0;
            r_fill    <= '0;
            r_bitcnt  <= '0;
            r_wordcnt <= '0;
            r_missed  <= '0;
            q_data    <= '0;
            q_valid   <= 1'b0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            q_valid  <= 1'b0;
            sync_err <= 1'b0;
            if (e) begin
                r_sr <= w_nxt[WIDTH-2:0];
                unique case (r_state)
                    S_HUNT: begin
                        if (r_fill != FILL_MAX) begin
                            r_fill <= r_fill + FW'(1);
                        end
                        if (r_fill >= FILL_MIN && w_nxt == SYNC) begin
                            r_state   <= S_LOCKED;
                            locked    <= 1'b1;
                            r_bitcnt  <= '0;
                            r_wordcnt <= '0;
                            r_missed  <= '0;
                        end
                    end
                    S_LOCKED: begin
                        if (r_bitcnt != BIT_LAST) begin
                            r_bitcnt <= r_bitcnt + BW'(1);
                        end else begin
                            r_bitcnt <= '0;
                            if (r_wordcnt != WORD_SYNC) begin
                                q_data    <= w_nxt;
                                q_valid   <= 1'b1;
                                r_wordcnt <= r_wordcnt + WW'(1);
                            end else begin
                                r_wordcnt <= '0;
                                if (w_nxt == SYNC) begin
                                    r_missed <= '0;
                                end else begin
                                    sync_err <= 1'b1;
                                    // Stale bits are discarded: hunt restarts empty.
                                    if (r_missed == MISS_LAST) begin
                                        r_state  <= S_HUNT;
                                        locked   <= 1'b0;
                                        r_fill   <= '0;
                                        r_missed <= '0;
                                    end else begin
                                        r_missed <= r_missed + MW'(1);
                                    end
                                end
                            end
                        end
                    end
                    default: r_state <= S_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_word_deframer.sv
// Directed table-driven bench for serial_word_deframer.
module tb_serial_word_deframer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i   = 1'b0;
    logic       e   = 1'b0;
    logic [7:0] q_data, q_data2;
    logic       q_valid, locked, sync_err;
    logic       q_valid2, locked2, sync_err2;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_qd;
    logic       exp_lk;

    typedef struct {
        logic [7:0] w;
        logic       vld;
        logic       serr;
        logic       lk;
    } vec_t;

    vec_t tbl [25];

    always #5 clk = ~clk;

    serial_word_deframer #(.WIDTH(8), .SYNC(8'hA5), .FRAME_WORDS(4), .MISS_MAX(2)) u_dut (
        .clk(clk), .rst(rst), .i(i), .e(e),
        .q_data(q_data), .q_valid(q_valid), .locked(locked), .sync_err(sync_err)
    );

    serial_word_deframer #(.WIDTH(8), .SYNC(8'h05), .FRAME_WORDS(4), .MISS_MAX(2)) u_dut5 (
        .clk(clk), .rst(rst), .i(i), .e(e),
        .q_data(q_data2), .q_valid(q_valid2), .locked(locked2), .sync_err(sync_err2)
    );

    task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s {vld,serr,lk,qd} act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step(input logic b, input logic en);
        @(negedge clk);
        i = b;
        e = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rst = 1'b1;
            i = 1'($urandom);
            e = 1'($urandom);
            @(posedge clk);
            #1;
            chk("reset", {q_valid, sync_err, locked, q_data}, 11'h000);
        end
        @(negedge clk);
        rst = 1'b0;
        e = 1'b0;
        exp_qd = 8'h00;
        exp_lk = 1'b0;
    endtask

    task automatic run_vec(input int idx, input bit gap);
        vec_t v;
        v = tbl[idx];
        for (int b = 7; b >= 0; b--) begin
            step(v.w[b], 1'b1);
            if (b != 0) begin
                chk($sformatf("vec%0d_bit%0d", idx, b),
                    {q_valid, sync_err, locked, q_data}, {2'b00, exp_lk, exp_qd});
            end else begin
                if (v.vld) exp_qd = v.w;
                exp_lk = v.lk;
                chk($sformatf("vec%0d_word", idx),
                    {q_valid, sync_err, locked, q_data}, {v.vld, v.serr, exp_lk, exp_qd});
            end
            if (gap) begin
                step(1'b1, 1'b0);
                chk($sformatf("vec%0d_gap%0d", idx, b),
                    {q_valid, sync_err, locked, q_data}, {2'b00, exp_lk, exp_qd});
            end
        end
    endtask

    initial begin
        logic [10:0] fg_bits;
        logic [31:0] w32;

        tbl[0]  = '{8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{8'h12, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{8'h34, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{8'h56, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{8'h78, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{8'h00, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{8'h9A, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{8'hBC, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{8'hDE, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{8'hF0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{8'h11, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{8'h22, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{8'h33, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{8'h44, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{8'h00, 1'b0, 1'b1, 1'b1};
        tbl[16] = '{8'h55, 1'b1, 1'b0, 1'b1};
        tbl[17] = '{8'h66, 1'b1, 1'b0, 1'b1};
        tbl[18] = '{8'h77, 1'b1, 1'b0, 1'b1};
        tbl[19] = '{8'h88, 1'b1, 1'b0, 1'b1};
        tbl[20] = '{8'hFF, 1'b0, 1'b1, 1'b0};
        tbl[21] = '{8'h00, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{8'h00, 1'b0, 1'b0, 1'b0};
        tbl[23] = '{8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[24] = '{8'h3C, 1'b1, 1'b0, 1'b1};

        exp_qd = 8'h00;
        exp_lk = 1'b0;

        // Continuous stream, sync checks, lock drop and relock
        do_reset(2);
        for (int k = 0; k < 25; k++) run_vec(k, 1'b0);

        // Gapped enable
        do_reset(1);
        for (int k = 0; k < 5; k++) run_vec(k, 1'b1);

        // Fill guard on the SYNC=05 instance
        do_reset(1);
        fg_bits = 11'b101_00000101;
        for (int b = 10; b >= 0; b--) begin
            step(fg_bits[b], 1'b1);
            chk($sformatf("fill_guard_bit%0d", 10 - b),
                {q_valid2, sync_err2, locked2, q_data2},
                {2'b00, (b == 0), 8'h00});
        end

        // Reset in the middle of a data word
        do_reset(1);
        run_vec(0, 1'b0);
        for (int b = 0; b < 3; b++) begin
            step(1'b0, 1'b1);
            chk("mid_word_bits", {q_valid, sync_err, locked, q_data}, {2'b00, 1'b1, 8'h00});
        end
        @(negedge clk);
        rst = 1'b1;
        i = 1'b1;
        e = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_word_rst", {q_valid, sync_err, locked, q_data}, 11'h000);
        @(negedge clk);
        rst = 1'b0;
        exp_qd = 8'h00;
        exp_lk = 1'b0;
        run_vec(23, 1'b0);
        run_vec(24, 1'b0);

        w32 = 32'(total);
        $display("test done: total=%0d bad=%0d", w32, bad);
        $finish;
    end

endmodule

// File: doc/serial_word_deframer.md
Name: serial_word_deframer

Overview:
- Consumes the serial bit stream and bit-enable of the enabled shift-register/SRL delay stage, and assembles it into parallel words.
- Hunts for a sync word and locks onto it.
- Once locked, emits FRAME_WORDS data words per frame and checks the sync slot that follows each frame.
- Drops lock after MISS_MAX consecutive bad sync slots.

Parameters:
- WIDTH, 8: word width in bits; must be 2 or more.
- SYNC, 8'hA5: sync pattern, WIDTH bits.
- FRAME_WORDS, 4: data words between sync slots; must be 1 or more.
- MISS_MAX, 2: consecutive bad sync slots that drop lock; must be 1 or more.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- i  input  1  serial data bit.
- e  input  1  bit enable; i is sampled only on edges where e=1.
- q_data  output  WIDTH  last assembled data word.
- q_valid  output  1  one-cycle pulse: q_data updated.
- locked  output  1  high while in LOCKED.
- sync_err  output  1  one-cycle pulse: sync slot mismatched.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=HUNT; sr, fill, bitcnt, wordcnt, missed all 0.
  - q_data=0, q_valid=0, locked=0, sync_err=0.
  - rst has priority over everything. A partial word or frame is discarded and no pulse is produced.
- Bit order:
  - On each enabled edge, nxt = {sr[WIDTH-2:0], i}; sr <= nxt.
  - The first-received bit ends up in the MSB; the new bit enters the LSB.
- e=0:
  - sr, counters and state hold.
  - q_valid and sync_err are 0 on the following cycle.
  - q_data and locked hold.
- q_valid and sync_err are registered single-cycle pulses, high only in the cycle after the enabled edge that produced them. They are never high on consecutive cycles unless consecutive enabled edges complete words, which requires WIDTH=1 and is excluded.
- HUNT state:
  - fill saturates at WIDTH and counts enabled bits since entering HUNT.
  - A match requires an enabled edge with fill ≥ WIDTH-1 (i.e. at least WIDTH valid bits including the current one) and nxt==SYNC.
  - On a match: state<=LOCKED, locked<=1, bitcnt<=0, wordcnt<=0, missed<=0.
  - A match produces no q_valid.
- LOCKED state: on each enabled edge, bitcnt increments. When bitcnt==WIDTH-1 the word completes with value nxt, and bitcnt<=0.
  - If wordcnt<FRAME_WORDS (data slot):
    - q_data<=nxt, q_valid<=1, wordcnt++.
  - If wordcnt==FRAME_WORDS (sync slot):
    - wordcnt<=0 and q_data is unchanged.
    - If nxt==SYNC: missed<=0.
    - Otherwise: sync_err<=1 and missed++.
    - If missed+1==MISS_MAX: state<=HUNT, locked<=0, fill<=0, missed<=0. Bits already received are not reused for hunting.
- Latency: the final bit of a word is sampled at edge N; q_data and q_valid are visible from edge N until edge N+1. Lock is visible one cycle after the final sync bit is sampled.
- Widths:
  - bitcnt is clog2(WIDTH).
  - wordcnt is clog2(FRAME_WORDS+1).
  - missed is clog2(MISS_MAX+1).
  - Counters never wrap past their limits.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random i and e -> q_data=0, q_valid=0, locked=0, sync_err=0 throughout.
- Continuous stream, e=1, defaults: send A5 then 12,34,56,78, MSB first.
  - locked rises the cycle after the 8th bit.
  - q_valid pulses 4 times, exactly 8 cycles apart, with q_data=12,34,56,78.
  - No pulse for A5.
- Gapped enable: same stream with e alternating 1,0 -> identical words; pulses 16 cycles apart; no state change on e=0 cycles.
- Sync check:
  - After a frame, sync slot=00 -> sync_err one pulse, locked stays 1.
  - Next sync slot=A5 -> missed cleared.
  - Then two consecutive bad slots (00, FF) -> two sync_err pulses; locked falls the cycle after the last bit of the FF slot.
  - Subsequent data bits produce no q_valid until A5 is seen again.
- Fill guard, SYNC=8'h05 instance: after reset send 1,0,1 -> no lock (fill<8). Then send 0,0,0,0,0,1,0,1 -> locked after the 8th bit.
- Reset mid-word: lock with A5, send 3 bits of a data word, assert rst for 1 cycle -> locked=0 next cycle, no q_valid. A fresh A5 relocks and the next word is captured correctly.
